// File: rtl/key_param_pkg.sv
// Shared types and helpers for the key-driven parameter adjuster.
package key_param_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam logic KEY_ACTIVE = 1'b0;
  localparam int   CNT_W      = 24;
  localparam int   ARITH_W    = 17;

  // One bound-limited step; one bit wider than the widest register, so nothing wraps
  function automatic logic [ARITH_W-1:0] sat_step(
    input logic [ARITH_W-1:0] val,
    input logic [ARITH_W-1:0] step,
    input logic [ARITH_W-1:0] lo,
    input logic [ARITH_W-1:0] hi,
    input logic               up
  );
    logic [ARITH_W-1:0] res;
    if (up) begin
      if (val > hi - step) res = hi;
      else                 res = val + step;
    end else begin
      if (val < lo + step) res = lo;
      else                 res = val - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce_edge.sv
// Per-key 2-FF synchroniser, counter debounce and one-cycle press-edge detector.
module key_debounce_edge
  import key_param_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 250_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic stable_o,
  output logic press_o
);

  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  (* ASYNC_REG = "TRUE" *) logic sync2_q;
  logic             stable_q, stable_d;
  logic             edge_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stable level only follows the synchronised key after DEBOUNCE_TICKS+1 differing cycles
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_TICKS)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      edge_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      edge_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = edge_q & ~stable_q;

endmodule

// File: rtl/key_param_adjust.sv
// Three-key runtime tuner: INC/DEC with auto-repeat and saturation, SEL cycles the
// target register, INC+DEC together restores the initial value.
module key_param_adjust
  import key_param_pkg::*;
#(
  parameter int unsigned W              = 8,
  parameter int unsigned NUM_PARAMS     = 3,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned DEBOUNCE_TICKS = 250_000,
  parameter int unsigned REPEAT_DELAY   = 12_500_000,
  parameter int unsigned REPEAT_PERIOD  = 2_500_000,
  parameter int unsigned P_INIT         = 128,
  parameter int unsigned P_STEP         = 10,
  parameter int unsigned P_MIN          = 0,
  parameter int unsigned P_MAX          = (1 << W) - 1
) (
  input  logic                    clk_pixel_division,
  input  logic                    rst_n,
  input  logic                    key_inc,
  input  logic                    key_dec,
  input  logic                    key_sel,
  output logic [NUM_PARAMS*W-1:0] param_bus,
  output logic [SEL_W-1:0]        sel_idx,
  output logic                    update_pulse
);

  logic inc_stable, dec_stable, press_inc, press_dec, press_sel;

  key_debounce_edge #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_inc (
    .clk_i(clk_pixel_division), .rst_ni(rst_n), .key_i(key_inc),
    .stable_o(inc_stable), .press_o(press_inc));
  key_debounce_edge #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_dec (
    .clk_i(clk_pixel_division), .rst_ni(rst_n), .key_i(key_dec),
    .stable_o(dec_stable), .press_o(press_dec));
  key_debounce_edge #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_sel (
    .clk_i(clk_pixel_division), .rst_ni(rst_n), .key_i(key_sel),
    .stable_o(), .press_o(press_sel));

  rpt_state_e                 state_q;
  logic [CNT_W-1:0]           hold_cnt_q;
  logic                       dir_inc_q;
  logic [NUM_PARAMS*W-1:0]    bus_q, bus_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic                       update_q, update_d;
  logic                       inc_held, dec_held, dir_held, other_held, rep_pulse;
  logic                       restore, do_inc, do_dec;
  logic [W-1:0]               cur_val;
  logic [ARITH_W-1:0]         new_val;

  assign inc_held   = (inc_stable == KEY_ACTIVE);
  assign dec_held   = (dec_stable == KEY_ACTIVE);
  assign dir_held   = dir_inc_q ? inc_held : dec_held;
  assign other_held = dir_inc_q ? dec_held : inc_held;
  // Gated by the hold condition so a release never sneaks out one last repeat
  assign rep_pulse  = dir_held & ~other_held &
                      (((state_q == RPT_DELAY)  && (hold_cnt_q == CNT_W'(REPEAT_DELAY - 1))) ||
                       ((state_q == RPT_REPEAT) && (hold_cnt_q == CNT_W'(REPEAT_PERIOD - 1))));

  assign restore = (press_inc & dec_held) | (press_dec & inc_held) | (press_inc & press_dec);
  assign do_inc  = press_inc | (rep_pulse & dir_inc_q);
  assign do_dec  = press_dec | (rep_pulse & ~dir_inc_q);

  always_ff @(posedge clk_pixel_division or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RPT_IDLE;
      hold_cnt_q <= '0;
      dir_inc_q  <= 1'b0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if ((press_inc & ~dec_held) | (press_dec & ~inc_held)) begin
            state_q    <= RPT_DELAY;
            hold_cnt_q <= '0;
            dir_inc_q  <= press_inc;
          end
        end
        RPT_DELAY: begin
          if (!dir_held || other_held) begin
            state_q    <= RPT_IDLE;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            state_q    <= RPT_REPEAT;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (!dir_held || other_held) begin
            state_q    <= RPT_IDLE;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= RPT_IDLE;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  // Action targets the index held this cycle, even if SEL advances it on the same edge
  always_comb begin
    cur_val = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (sel_q == SEL_W'(i)) cur_val = bus_q[i*W +: W];
    end
    if (restore) begin
      new_val = ARITH_W'(P_INIT);
    end else begin
      new_val = sat_step(ARITH_W'(cur_val), ARITH_W'(P_STEP), ARITH_W'(P_MIN),
                         ARITH_W'(P_MAX), do_inc);
    end
    bus_d    = bus_q;
    update_d = 1'b0;
    if (restore | do_inc | do_dec) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (sel_q == SEL_W'(i)) bus_d[i*W +: W] = new_val[W-1:0];
      end
      update_d = (new_val != ARITH_W'(cur_val));
    end else begin
      update_d = 1'b0;
    end
    if (press_sel) begin
      sel_d = (sel_q == SEL_W'(NUM_PARAMS - 1)) ? '0 : sel_q + SEL_W'(1);
    end else begin
      sel_d = sel_q;
    end
  end

  always_ff @(posedge clk_pixel_division or negedge rst_n) begin
    if (!rst_n) begin
      bus_q    <= {NUM_PARAMS{W'(P_INIT)}};
      sel_q    <= '0;
      update_q <= 1'b0;
    end else begin
      bus_q    <= bus_d;
      sel_q    <= sel_d;
      update_q <= update_d;
    end
  end

  assign param_bus    = bus_q;
  assign sel_idx      = sel_q;
  assign update_pulse = update_q;

endmodule

// File: tb/tb_key_param_adjust.sv
// Scoreboard bench: each expected param_bus change is queued with its due cycle.
module tb_key_param_adjust;

  localparam int W = 8, NP = 3, DB = 4, RD = 20, RP = 5;
  localparam int INIT = 128, STEP = 10, PMIN = 0, PMAX = 255;
  localparam int LAT = 8;

  typedef struct {
    int          cyc;
    logic [23:0] bus;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_inc = 1'b1, key_dec = 1'b1, key_sel = 1'b1;
  logic [23:0] param_bus;
  logic [1:0]  sel_idx;
  logic        update_pulse;

  int          cyc = 0;
  int          n_tests = 0, n_fail = 0;
  int          p[NP];
  int          exp_sel = 0;
  logic [23:0] model_bus = {3{8'd128}};
  exp_t        sb[$];
  exp_t        e;

  key_param_adjust #(
    .W(W), .NUM_PARAMS(NP), .SEL_W(2), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .P_INIT(INIT), .P_STEP(STEP), .P_MIN(PMIN), .P_MAX(PMAX)
  ) dut (
    .clk_pixel_division(clk), .rst_n(rst_n), .key_inc(key_inc), .key_dec(key_dec),
    .key_sel(key_sel), .param_bus(param_bus), .sel_idx(sel_idx),
    .update_pulse(update_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, want, want, cyc);
    end
  endtask

  function automatic logic [23:0] pack_model();
    logic [23:0] b;
    for (int i = 0; i < NP; i++) b[i*W +: W] = 8'(p[i]);
    return b;
  endfunction

  // kind: 0 = increment, 1 = decrement, 2 = restore
  task automatic exp_step(input int due, input int idx, input int kind);
    int v, nv;
    exp_t x;
    v = p[idx];
    case (kind)
      0:       nv = (v + STEP > PMAX) ? PMAX : v + STEP;
      1:       nv = (v - STEP < PMIN) ? PMIN : v - STEP;
      default: nv = INIT;
    endcase
    if (nv != v) begin
      p[idx] = nv;
      x.cyc  = due;
      x.bus  = pack_model();
      sb.push_back(x);
    end
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Hold INC (is_dec=0) or DEC (is_dec=1) for 'hold' raw cycles, queueing every step
  task automatic hold_key(input int is_dec, input int hold);
    int n;
    n = cyc;
    if (is_dec != 0) key_dec = 1'b0;
    else             key_inc = 1'b0;
    exp_step(n + LAT, exp_sel, is_dec);
    for (int off = RD; off <= hold - 1; off += RP) exp_step(n + LAT + off, exp_sel, is_dec);
    wait_cyc(hold);
    key_inc = 1'b1;
    key_dec = 1'b1;
    wait_cyc(25);
  endtask

  task automatic glitch_inc(input int len);
    key_inc = 1'b0;
    wait_cyc(len);
    key_inc = 1'b1;
    wait_cyc(3);
  endtask

  task automatic press_sel();
    key_sel = 1'b0;
    wait_cyc(10);
    key_sel = 1'b1;
    wait_cyc(12);
    exp_sel = (exp_sel == NP - 1) ? 0 : exp_sel + 1;
    check_eq("sel_idx", 32'(sel_idx), 32'(exp_sel));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (update_pulse) begin
        if (sb.size() == 0) begin
          check_eq("spurious_pulse", 32'(update_pulse), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("pulse_cycle", 32'(cyc), 32'(e.cyc));
          check_eq("param_bus", 32'(param_bus), 32'(e.bus));
          model_bus = e.bus;
        end
      end else begin
        check_eq("param_hold", 32'(param_bus), 32'(model_bus));
      end
    end
  end

  initial begin
    int n, r;
    for (int i = 0; i < NP; i++) p[i] = INIT;
    wait_cyc(3);
    check_eq("rst_bus", 32'(param_bus), 32'h808080);
    check_eq("rst_sel", 32'(sel_idx), 32'd0);
    check_eq("rst_pulse", 32'(update_pulse), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Clean 10-cycle INC press: single step, no repeat
    n = cyc;
    key_inc = 1'b0;
    exp_step(n + LAT, 0, 0);
    wait_cyc(10);
    key_inc = 1'b1;
    wait_cyc(25);

    // Glitches and a bounce train never reach five stable cycles
    for (int g = 1; g <= 4; g++) glitch_inc(g);
    for (int b = 0; b < 3; b++) begin
      key_inc = 1'b0; wait_cyc(4);
      key_inc = 1'b1; wait_cyc(1);
    end
    wait_cyc(15);
    check_eq("glitch_sb", 32'(sb.size()), 32'd0);

    // Long INC hold: steps at +0, +20, then every 5 until the release lands
    hold_key(0, 58);
    check_eq("repeat_sb", 32'(sb.size()), 32'd0);

    // Two selects, then DEC on param2 down to the floor with no pulses while saturated
    press_sel();
    press_sel();
    hold_key(1, 100);
    check_eq("floor_p2", 32'(param_bus[23:16]), 32'd0);
    press_sel();

    // INC press then DEC while INC held: one step, then restore, repeat cancelled
    n = cyc;
    key_inc = 1'b0;
    exp_step(n + LAT, 0, 0);
    wait_cyc(12);
    key_dec = 1'b0;
    exp_step(n + 12 + LAT, 0, 2);
    wait_cyc(30);
    key_inc = 1'b1;
    key_dec = 1'b1;
    wait_cyc(30);
    check_eq("restore_p0", 32'(param_bus[7:0]), 32'(INIT));

    // Reset mid-repeat with INC still held
    n = cyc;
    key_inc = 1'b0;
    exp_step(n + LAT, 0, 0);
    exp_step(n + LAT + RD, 0, 0);
    wait_cyc(30);
    check_eq("pre_rst_sb", 32'(sb.size()), 32'd0);
    rst_n = 1'b0;
    for (int i = 0; i < NP; i++) p[i] = INIT;
    model_bus = pack_model();
    #1;
    check_eq("mid_rst_bus", 32'(param_bus), 32'h808080);
    check_eq("mid_rst_sel", 32'(sel_idx), 32'd0);
    exp_sel = 0;
    wait_cyc(3);
    rst_n = 1'b1;
    r = cyc;
    exp_step(r + LAT, 0, 0);
    wait_cyc(10);
    key_inc = 1'b1;
    wait_cyc(30);
    check_eq("final_sb", 32'(sb.size()), 32'd0);
    check_eq("final_sel", 32'(sel_idx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
